section_feeder: RTL

SECTION_FEEDER -- requirements
Module: section_feeder

---
 rtl/connect6_pkg.sv | 27 ++
 rtl/section_addr_gen.sv | 51 +++++
 rtl/section_feeder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/connect6_pkg.sv
// Shared constants, cell encodings and feeder FSM state encoding for the
// Connect6 board section feeder.
package connect6_pkg;

   localparam int unsigned BOARD_SIZE   = 19;
   localparam int unsigned CELL_BITS    = 2;
   localparam int unsigned NUM_SECTIONS = 2 * BOARD_SIZE;
   localparam int unsigned SEC_W        = BOARD_SIZE * CELL_BITS;
   localparam int unsigned ADDR_W       = 9;
   localparam int unsigned IDX_W        = 6;
   localparam int unsigned CNT_W        = 5;
   localparam int unsigned TOT_W        = 7;

   localparam logic [CELL_BITS-1:0] CELL_EMPTY = 2'b00;
   localparam logic [CELL_BITS-1:0] CELL_BLACK = 2'b10;
   localparam logic [CELL_BITS-1:0] CELL_WHITE = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_ACCUM  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/section_addr_gen.sv
// Board RAM address generator: keeps the base address of the current section
// and steps it with +1 / +BOARD_SIZE adders only (no multiplier).
module section_addr_gen #(
   parameter int unsigned BOARD_SIZE = 19
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_clear,
   input  logic                              i_advance,
   input  logic [connect6_pkg::IDX_W-1:0]    i_sec_index,
   input  logic [connect6_pkg::ADDR_W-1:0]   i_cur_addr,
   output logic [connect6_pkg::ADDR_W-1:0]   o_next_base_c,
   output logic [connect6_pkg::ADDR_W-1:0]   o_next_addr_c
);
   import connect6_pkg::*;

   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_base_next;
   logic [ADDR_W-1:0] w_stride;
   logic              w_is_row;

   // Rows walk along a row (+1); columns walk down a column (+BOARD_SIZE).
   always_comb begin
      w_is_row = (i_sec_index < IDX_W'(BOARD_SIZE));
      w_stride = w_is_row ? ADDR_W'(1) : ADDR_W'(BOARD_SIZE);
   end

   // Row bases step by a full row; the last row hands over to column 0.
   always_comb begin
      w_base_next = r_base;
      if (i_clear) begin
         w_base_next = '0;
      end else if (i_advance) begin
         if (i_sec_index == IDX_W'(BOARD_SIZE - 1))
            w_base_next = '0;
         else if (w_is_row)
            w_base_next = r_base + ADDR_W'(BOARD_SIZE);
         else
            w_base_next = r_base + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_base <= '0;
      else        r_base <= w_base_next;
   end

   assign o_next_base_c = w_base_next;
   assign o_next_addr_c = i_cur_addr + w_stride;

endmodule

// File: rtl/section_feeder.sv
// Scans all rows and columns of the board, assembles each into a section,
// hands it to the section processor and accumulates board-wide threat totals.
module section_feeder #(
   parameter int unsigned BOARD_SIZE = 19
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_start,
   output logic        scan_busy,
   output logic        scan_done,
   output logic        mem_rd_en,
   output logic [8:0]  mem_addr,
   input  logic [1:0]  mem_rd_data,
   output logic [37:0] section,
   output logic        sec_start,
   input  logic        sec_ready,
   output logic [5:0]  sec_index,
   input  logic [1:0]  num_t4_b,
   input  logic [1:0]  num_t3_b,
   input  logic [1:0]  num_t2_b,
   input  logic [1:0]  num_t4_w,
   input  logic [1:0]  num_t3_w,
   input  logic [1:0]  num_t2_w,
   output logic [6:0]  total_t4_b,
   output logic [6:0]  total_t3_b,
   output logic [6:0]  total_t2_b,
   output logic [6:0]  total_t4_w,
   output logic [6:0]  total_t3_w,
   output logic [6:0]  total_t2_w
);
   import connect6_pkg::*;

   localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(BOARD_SIZE - 1);
   localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(BOARD_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(2 * BOARD_SIZE - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wait_first;

   logic              w_scan_go;
   logic              w_fetch_enter;
   logic              w_issue_more;
   logic              w_rd_en_next;
   logic [ADDR_W-1:0] w_addr_next;
   logic              w_sec_start_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_slot_we;
   logic [CNT_W-1:0]  w_slot;
   logic              w_advance;
   logic [ADDR_W-1:0] w_next_base;
   logic [ADDR_W-1:0] w_next_addr;

   assign w_scan_go = (r_state == ST_IDLE) && scan_start;
   assign w_advance = (r_state == ST_ACCUM) && (sec_index != LAST_IDX);

   section_addr_gen #(.BOARD_SIZE(BOARD_SIZE)) u_addr_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (w_scan_go),
      .i_advance     (w_advance),
      .i_sec_index   (sec_index),
      .i_cur_addr    (mem_addr),
      .o_next_base_c (w_next_base),
      .o_next_addr_c (w_next_addr)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; the first WAIT cycle never samples sec_ready.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (scan_start) w_state_next = ST_FETCH;
         ST_FETCH:  if (r_cnt == FETCH_END) w_state_next = ST_LAUNCH;
         ST_LAUNCH: w_state_next = ST_WAIT;
         ST_WAIT:   if (!r_wait_first && sec_ready) w_state_next = ST_ACCUM;
         ST_ACCUM:  w_state_next = (sec_index == LAST_IDX) ? ST_DONE : ST_FETCH;
         ST_DONE:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Output logic: next values for the registered strobes and address.
   always_comb begin
      w_fetch_enter    = (w_state_next == ST_FETCH) && (r_state != ST_FETCH);
      w_issue_more     = (r_state == ST_FETCH) && (r_cnt < LAST_K);
      w_rd_en_next     = w_fetch_enter || w_issue_more;
      w_addr_next      = mem_addr;
      if (w_fetch_enter)     w_addr_next = w_next_base;
      else if (w_issue_more) w_addr_next = w_next_addr;
      w_sec_start_next = (r_state == ST_FETCH) && (r_cnt == FETCH_END);
      w_busy_next      = (w_state_next == ST_FETCH) || (w_state_next == ST_LAUNCH) ||
                         (w_state_next == ST_WAIT)  || (w_state_next == ST_ACCUM);
      w_done_next      = (w_state_next == ST_DONE);
      w_slot_we        = (r_state == ST_FETCH) && (r_cnt != '0);
      w_slot           = r_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         sec_start    <= 1'b0;
         scan_busy    <= 1'b0;
         scan_done    <= 1'b0;
         r_cnt        <= '0;
         r_wait_first <= 1'b0;
      end else begin
         mem_rd_en <= w_rd_en_next;
         mem_addr  <= w_addr_next;
         sec_start <= w_sec_start_next;
         scan_busy <= w_busy_next;
         scan_done <= w_done_next;
         if (w_fetch_enter)              r_cnt <= '0;
         else if (r_state == ST_FETCH)   r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == ST_LAUNCH)       r_wait_first <= 1'b1;
         else if (r_state == ST_WAIT)    r_wait_first <= 1'b0;
      end
   end

   // Read data for cell k arrives one cycle after its address; store in slot k.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         section <= '0;
      end else if (w_slot_we) begin
         for (int k = 0; k < 19; k++) begin
            if (w_slot == CNT_W'(k)) section[37-2*k -: 2] <= mem_rd_data;
         end
      end
   end

   // Section index and board-wide totals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_index  <= '0;
         total_t4_b <= '0;
         total_t3_b <= '0;
         total_t2_b <= '0;
         total_t4_w <= '0;
         total_t3_w <= '0;
         total_t2_w <= '0;
      end else if (w_scan_go) begin
         sec_index  <= '0;
         total_t4_b <= '0;
         total_t3_b <= '0;
         total_t2_b <= '0;
         total_t4_w <= '0;
         total_t3_w <= '0;
         total_t2_w <= '0;
      end else if (r_state == ST_ACCUM) begin
         total_t4_b <= total_t4_b + TOT_W'(num_t4_b);
         total_t3_b <= total_t3_b + TOT_W'(num_t3_b);
         total_t2_b <= total_t2_b + TOT_W'(num_t2_b);
         total_t4_w <= total_t4_w + TOT_W'(num_t4_w);
         total_t3_w <= total_t3_w + TOT_W'(num_t3_w);
         total_t2_w <= total_t2_w + TOT_W'(num_t2_w);
         if (w_advance) sec_index <= sec_index + IDX_W'(1);
      end
   end

endmodule
